// File: rtl/bcd_conv_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_conv_arbiter
//
// Shares one binary-to-BCD converter among NUM_REQ requesters (overlay
// fields such as frame counters, coordinates and debug registers). Requesters
// are served round-robin, one conversion at a time. The converter's
// start/done handshake is sequenced here, and each result goes back to the
// requester that asked for it.
//
// Ports
//   clk          clock, shared with the converter
//   reset_n      asynchronous active-low reset (release is synchronised
//                upstream)
//   req_valid    per-requester request; held with req_binary until accepted
//   req_binary   packed per-requester operands; requester i occupies
//                bits [i*BINARY_DATA_WIDTH +: BINARY_DATA_WIDTH]
//   req_ready    one-hot acceptance; a transfer is req_valid[i] & req_ready[i]
//   rsp_valid    one-hot, single-cycle pulse marking the owner of rsp_bcd
//   rsp_bcd      last conversion result, most significant digit in the top
//                nibble; held until the next result
//   busy         high whenever a conversion is in flight (not IDLE)
//   conv_start   single-cycle start pulse to the converter
//   conv_binary  operand to the converter; stable from start until next grant
//   conv_done    converter done pulse (honoured only while waiting for it)
//   conv_bcd     converter result, valid in the conv_done cycle
// ---------------------------------------------------------------------------
module bcd_conv_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int BINARY_DATA_WIDTH = 16,
    parameter int BCD_DIGITS        = 5,
    parameter int BCD_DIGIT_WIDTH   = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*BINARY_DATA_WIDTH-1:0]  req_binary,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [BCD_DIGITS*BCD_DIGIT_WIDTH-1:0] rsp_bcd,
    output logic                                  busy,
    output logic                                  conv_start,
    output logic [BINARY_DATA_WIDTH-1:0]          conv_binary,
    input  logic                                  conv_done,
    input  logic [BCD_DIGITS*BCD_DIGIT_WIDTH-1:0] conv_bcd
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int BCD_W = BCD_DIGITS * BCD_DIGIT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                         state_reg, state_next;
    logic [PTR_W-1:0]               ptr_reg, ptr_next;
    logic [PTR_W-1:0]               grant_reg, grant_next;
    logic [BINARY_DATA_WIDTH-1:0]   conv_binary_reg, conv_binary_next;
    logic [BCD_W-1:0]               rsp_bcd_reg, rsp_bcd_next;

    // Round-robin search helpers: candidate k of the scan is requester
    // (ptr + k) mod NUM_REQ.
    logic [BINARY_DATA_WIDTH-1:0]   req_bin_arr [NUM_REQ];
    logic [PTR_W-1:0]               rot_idx     [NUM_REQ];
    logic [NUM_REQ-1:0]             rot_valid;
    logic [PTR_W-1:0]               winner;
    logic                           any_valid;

    genvar gi;

    // Unpack the flat operand bus into one word per requester.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_bin_arr[gi] = req_binary[gi*BINARY_DATA_WIDTH +: BINARY_DATA_WIDTH];
        end
    endgenerate

    // Rotated candidate indices. The sum is one bit wider than the pointer so
    // that ptr + k (at most 2*NUM_REQ-2) never overflows before the wrap; the
    // wrap subtracts NUM_REQ explicitly so non-power-of-2 counts work.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [PTR_W:0] rot_sum;
            logic [PTR_W:0] rot_wrap;

            assign rot_sum  = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
            assign rot_wrap = (rot_sum >= (PTR_W+1)'(NUM_REQ))
                            ? rot_sum - (PTR_W+1)'(NUM_REQ)
                            : rot_sum;
            assign rot_idx[gi]   = rot_wrap[PTR_W-1:0];
            assign rot_valid[gi] = req_valid[rot_idx[gi]];
        end
    endgenerate

    // First valid candidate in scan order wins. Scanning from the far end
    // downward lets the lowest offset (closest to ptr) overwrite the rest.
    always_comb begin
        winner    = '0;
        any_valid = |rot_valid;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                winner = rot_idx[k];
            end
        end
    end

    // Acceptance is combinational so a requester sees ready in the same cycle
    // it is chosen. It is forced low while reset is asserted, because the
    // reset state is IDLE and would otherwise advertise a grant that the
    // held-in-reset registers cannot take.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = reset_n
                                 && (state_reg == ST_IDLE)
                                 && any_valid
                                 && (winner == PTR_W'(gi));
        end
    endgenerate

    // Response strobe goes only to the requester that owns the result.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = (state_reg == ST_RESP) && (grant_reg == PTR_W'(gi));
        end
    endgenerate

    // Next-state and datapath update.
    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        grant_next       = grant_reg;
        conv_binary_next = conv_binary_reg;
        rsp_bcd_next     = rsp_bcd_reg;

        case (state_reg)
            ST_IDLE: begin
                // Any valid request implies the winner sees ready, so a
                // transfer happens whenever some request is pending.
                if (any_valid) begin
                    conv_binary_next = req_bin_arr[winner];
                    grant_next       = winner;
                    ptr_next         = (winner == PTR_W'(NUM_REQ - 1))
                                     ? '0
                                     : winner + PTR_W'(1);
                    state_next       = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A done pulse in any other state is stray and is ignored.
                if (conv_done) begin
                    rsp_bcd_next = conv_bcd;
                    state_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            ptr_reg         <= '0;
            grant_reg       <= '0;
            conv_binary_reg <= '0;
            rsp_bcd_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            grant_reg       <= grant_next;
            conv_binary_reg <= conv_binary_next;
            rsp_bcd_reg     <= rsp_bcd_next;
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign conv_start  = (state_reg == ST_START);
    assign conv_binary = conv_binary_reg;
    assign rsp_bcd     = rsp_bcd_reg;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_bcd_conv_arbiter
//
// Directed bench for bcd_conv_arbiter with a behavioural converter
// (done BINARY_DATA_WIDTH+2 cycles after start) and a cycle-level reference
// model that checks every DUT output on every negative clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_conv_arbiter;

    localparam int N        = 4;
    localparam int W        = 16;
    localparam int D        = 5;
    localparam int DW       = 4;
    localparam int BW       = D * DW;
    localparam int CONV_LAT = W + 2;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N-1:0]        req_valid;
    logic [N*W-1:0]      req_binary;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    logic [BW-1:0]       rsp_bcd;
    logic                busy;
    logic                conv_start;
    logic [W-1:0]        conv_binary;
    logic                conv_done;
    logic [BW-1:0]       conv_bcd;

    logic                model_done;
    logic                spur_done;
    logic [BW-1:0]       model_bcd;

    always #5 clk = ~clk;

    assign conv_done = model_done | spur_done;
    assign conv_bcd  = model_done ? model_bcd : '1;

    bcd_conv_arbiter #(
        .NUM_REQ          (N),
        .BINARY_DATA_WIDTH(W),
        .BCD_DIGITS       (D),
        .BCD_DIGIT_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_binary (req_binary),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_bcd    (rsp_bcd),
        .busy       (busy),
        .conv_start (conv_start),
        .conv_binary(conv_binary),
        .conv_done  (conv_done),
        .conv_bcd   (conv_bcd)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits by plain division, least significant digit lowest.
    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < D; k++) begin
            r[k*DW +: DW] = DW'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // ---------------- behavioural converter ----------------
    int       conv_cnt;
    logic [W-1:0] conv_op;

    initial begin
        model_done = 1'b0;
        model_bcd  = '0;
        conv_cnt   = 0;
        conv_op    = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                conv_cnt   = 0;
                model_done = 1'b0;
            end else begin
                model_done = 1'b0;
                if (conv_cnt > 0) begin
                    conv_cnt--;
                    if (conv_cnt == 0) begin
                        model_done = 1'b1;
                        model_bcd  = to_bcd(int'(conv_op));
                    end
                end
                if (conv_start) begin
                    conv_op  = conv_binary;
                    conv_cnt = CONV_LAT;
                end
            end
        end
    end

    // ---------------- reference model and compare ----------------
    int            cyc;
    bit            m_free;
    int            m_ptr, m_g, m_start_cyc, m_rsp_cyc, m_w;
    logic [W-1:0]  m_bin;
    logic [BW-1:0] m_bcd;
    logic [N-1:0]  exp_ready, exp_rsp, acc_last;
    int            grant_log[$];
    logic [N+BW-1:0] rsp_log[$];

    task automatic model_reset();
        m_free      = 1'b1;
        m_ptr       = 0;
        m_g         = 0;
        m_start_cyc = -10;
        m_rsp_cyc   = -10;
        m_bin       = '0;
        m_bcd       = '0;
    endtask

    initial begin
        cyc      = 0;
        acc_last = '0;
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                model_reset();
                acc_last = '0;
            end else begin
                m_w = -1;
                if (m_free) begin
                    for (int k = 0; k < N; k++) begin
                        if (m_w < 0 && req_valid[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
                    end
                end
                exp_ready = (m_w >= 0) ? N'(1 << m_w) : '0;
                exp_rsp   = (!m_free && cyc == m_rsp_cyc) ? N'(1 << m_g) : '0;

                chk("busy",        busy,        !m_free);
                chk("req_ready",   req_ready,   exp_ready);
                chk("conv_start",  conv_start,  (!m_free && cyc == m_start_cyc));
                chk("rsp_valid",   rsp_valid,   exp_rsp);
                chk("conv_binary", conv_binary, m_bin);
                chk("rsp_bcd",     rsp_bcd,     m_bcd);

                acc_last = req_valid & req_ready;
                for (int k = 0; k < N; k++) if (acc_last[k]) grant_log.push_back(k);
                if (rsp_valid != '0) rsp_log.push_back({rsp_valid, rsp_bcd});

                if (m_w >= 0) begin
                    m_free      = 1'b0;
                    m_g         = m_w;
                    m_bin       = req_binary[m_w*W +: W];
                    m_start_cyc = cyc + 1;
                    m_rsp_cyc   = -1;
                    m_ptr       = (m_w + 1) % N;
                end else if (!m_free) begin
                    if (cyc == m_rsp_cyc) begin
                        m_free = 1'b1;
                    end else if (m_rsp_cyc < 0 && cyc > m_start_cyc && conv_done) begin
                        m_rsp_cyc = cyc + 1;
                        m_bcd     = to_bcd(int'(m_bin));
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit auto_drop;

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~acc_last;
    endtask

    task automatic set_bin(input int i, input int v);
        req_binary[i*W +: W] = W'(v);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_busy",        busy,        0);
        chk("rst_req_ready",   req_ready,   0);
        chk("rst_rsp_valid",   rsp_valid,   0);
        chk("rst_conv_start",  conv_start,  0);
        chk("rst_conv_binary", conv_binary, 0);
        chk("rst_rsp_bcd",     rsp_bcd,     0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int start;
        int c;
        start = rsp_log.size();
        c = 0;
        while (rsp_log.size() < start + n && c < budget) begin
            step();
            c++;
        end
        chk("rsp_count", rsp_log.size() - start, n);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int start;
        int c;
        start = grant_log.size();
        c = 0;
        while (grant_log.size() < start + n && c < budget) begin
            step();
            c++;
        end
        chk("grant_count", grant_log.size() - start, n);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            step();
            c++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    int              gl0, rl0, pv;
    logic [N+BW-1:0] e;
    logic [BW-1:0]   t2_exp [4];
    logic [BW-1:0]   t4_exp [3];
    int              t4_val [3];
    int              t3_exp [6];

    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        req_binary = '0;
        spur_done  = 1'b0;
        auto_drop  = 1'b1;
        t2_exp = '{20'h00010, 20'h00020, 20'h00030, 20'h00040};
        t4_val = '{0, 65535, 9};
        t4_exp = '{20'h00000, 20'h65535, 20'h00009};
        t3_exp = '{1, 3, 1, 3, 1, 3};

        // pin the reference digit model
        pv = 1234;  chk("pin_1234",  to_bcd(pv), 20'h01234);
        pv = 65535; chk("pin_65535", to_bcd(pv), 20'h65535);
        pv = 0;     chk("pin_0",     to_bcd(pv), 20'h00000);
        pv = 9;     chk("pin_9",     to_bcd(pv), 20'h00009);

        apply_reset();

        // single request on requester 2
        step();
        set_bin(2, 1234);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0100);
        step();
        @(negedge clk);
        chk("t1_start", conv_start, 1);
        wait_rsp(1, 60);
        chk("t1_rsp", rsp_log[rsp_log.size()-1], {4'b0100, 20'h01234});
        chk("t1_busy_after", busy, 0);
        $display("t1 single req2 value 1234 -> rsp %h", rsp_bcd);

        // all four requesters after reset
        req_valid = '0;
        apply_reset();
        set_bin(0, 10); set_bin(1, 20); set_bin(2, 30); set_bin(3, 40);
        step();
        gl0 = grant_log.size();
        rl0 = rsp_log.size();
        req_valid = 4'b1111;
        wait_rsp(4, 200);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_grant%0d", k), grant_log[gl0+k], k);
            e = {N'(1 << k), t2_exp[k]};
            chk($sformatf("t2_rsp%0d", k), rsp_log[rl0+k], e);
            $display("t2 grant %0d rsp %h", grant_log[gl0+k], rsp_log[rl0+k]);
        end
        wait_idle(40);

        // fairness: requesters 1 and 3 held continuously
        auto_drop = 1'b0;
        set_bin(1, 111); set_bin(3, 333);
        step();
        gl0 = grant_log.size();
        req_valid = 4'b1010;
        wait_grants(6, 400);
        req_valid = '0;
        wait_idle(60);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_grant%0d", k), grant_log[gl0+k], t3_exp[k]);
            $display("t3 conversion %0d granted to %0d", k, grant_log[gl0+k]);
        end
        auto_drop = 1'b1;

        // boundary values on requester 0
        for (int k = 0; k < 3; k++) begin
            step();
            set_bin(0, t4_val[k]);
            req_valid = 4'b0001;
            wait_rsp(1, 60);
            e = {4'b0001, t4_exp[k]};
            chk($sformatf("t4_rsp%0d", k), rsp_log[rsp_log.size()-1], e);
            repeat (3) step();
            chk($sformatf("t4_hold%0d", k), rsp_bcd, t4_exp[k]);
            $display("t4 value %0d -> rsp %h", t4_val[k], rsp_bcd);
        end

        // stray done while idle, then during START
        rl0 = rsp_log.size();
        step();
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        step();
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_norsp", rsp_log.size() - rl0, 0);
        set_bin(1, 4321);
        req_valid = 4'b0010;
        step();
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        chk("t5_start_busy", busy, 1);
        wait_rsp(1, 60);
        chk("t5_rsp", rsp_log[rsp_log.size()-1], {4'b0010, 20'h04321});
        $display("t5 stray done ignored, req1 -> rsp %h", rsp_bcd);

        // asynchronous reset in the middle of a conversion
        step();
        set_bin(2, 777);
        req_valid = 4'b0100;
        wait_grants(1, 20);
        repeat (5) step();
        chk("t6_busy_before", busy, 1);
        rl0 = rsp_log.size();
        apply_reset();
        repeat (30) step();
        chk("t6_no_rsp", rsp_log.size() - rl0, 0);
        $display("t6 reset mid-wait, responses after reset %0d", rsp_log.size() - rl0);

        // pointer back at 0: requester 1 must win over 3
        set_bin(1, 42); set_bin(3, 99);
        gl0 = grant_log.size();
        rl0 = rsp_log.size();
        req_valid = 4'b1010;
        wait_rsp(2, 120);
        chk("t6_grant_first", grant_log[gl0], 1);
        chk("t6_grant_second", grant_log[gl0+1], 3);
        chk("t6_rsp_first", rsp_log[rl0], {4'b0010, 20'h00042});
        chk("t6_rsp_second", rsp_log[rl0+1], {4'b1000, 20'h00099});
        $display("t6 after reset grants %0d,%0d", grant_log[gl0], grant_log[gl0+1]);
        wait_idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
